text_writer: RTL



---
 rtl/text_writer_pkg.sv | 26 ++
 rtl/text_writer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/text_writer_pkg.sv
// Text-mode constants shared by the writer, the character counter and the RAM
// wrapper: grid size, fill code, control codes and the writer state encoding.
package text_writer_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 24;
  localparam int unsigned CHARS  = COLS * ROWS;
  localparam int unsigned ADDR_W = 11;
  localparam logic [7:0]  BLANK  = 8'h20;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_LINE
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_writer.sv
// Byte-stream text writer: keeps a cursor on the character grid, interprets
// LF/CR/BS/FF and writes characters and blank fills into the text RAM.
module text_writer #(
  parameter int unsigned COLS  = text_writer_pkg::COLS,
  parameter int unsigned ROWS  = text_writer_pkg::ROWS,
  parameter logic [7:0]  BLANK = text_writer_pkg::BLANK
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [7:0]                          in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                wr_en,
  output logic [text_writer_pkg::ADDR_W-1:0]  wr_addr,
  output logic [7:0]                          wr_data,
  output logic [text_writer_pkg::ADDR_W-1:0]  cursor_addr
);

  import text_writer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(COLS);
  localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);

  state_t              r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_nx;
  logic [ADDR_W-1:0]   r_base, w_base_nx;
  logic [4:0]          r_row, w_row_nx;
  logic [6:0]          r_col, w_col_nx;
  logic                r_done, w_done_nx;
  logic                r_wr_en, w_wr_en_nx;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nx;
  logic [7:0]          r_wr_data, w_wr_data_nx;

  logic                w_accept;
  logic                w_newline;
  logic [ADDR_W-1:0]   w_cursor;
  logic [ADDR_W-1:0]   w_clr_end;

  assign w_cursor  = r_base + ADDR_W'(r_col);
  assign w_accept  = in_valid && in_ready;
  // One clear pointer serves both clear modes; only the end address differs.
  assign w_clr_end = (r_state == CLEAR_ALL) ? LAST_ADDR
                                            : r_base + LINE_STEP - ADDR_W'(1);

  always_comb begin
    w_state_nx   = r_state;
    w_ptr_nx     = r_ptr;
    w_base_nx    = r_base;
    w_row_nx     = r_row;
    w_col_nx     = r_col;
    w_done_nx    = r_done;
    w_wr_en_nx   = 1'b0;
    w_wr_addr_nx = r_wr_addr;
    w_wr_data_nx = r_wr_data;
    w_newline    = 1'b0;

    case (r_state)
      CLEAR_ALL, CLEAR_LINE: begin
        // After the last fill write, one quiet cycle before accepting bytes.
        if (r_done) begin
          w_done_nx  = 1'b0;
          w_state_nx = IDLE;
          if (r_state == CLEAR_ALL) begin
            w_row_nx  = '0;
            w_col_nx  = '0;
            w_base_nx = '0;
          end
        end else begin
          w_wr_en_nx   = 1'b1;
          w_wr_addr_nx = r_ptr;
          w_wr_data_nx = BLANK;
          if (r_ptr == w_clr_end) w_done_nx = 1'b1;
          else                    w_ptr_nx  = r_ptr + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (w_accept) begin
          if (is_printable(in_data)) begin
            w_wr_en_nx   = 1'b1;
            w_wr_addr_nx = w_cursor;
            w_wr_data_nx = in_data;
            if (r_col == COL_LAST) w_newline = 1'b1;
            else                   w_col_nx  = r_col + 7'd1;
          end else begin
            case (in_data)
              LF: w_newline = 1'b1;
              CR: w_col_nx  = '0;
              BS: begin
                if (r_col != 7'd0) begin
                  w_col_nx     = r_col - 7'd1;
                  w_wr_en_nx   = 1'b1;
                  w_wr_addr_nx = w_cursor - ADDR_W'(1);
                  w_wr_data_nx = BLANK;
                end
              end
              FF: begin
                w_row_nx   = '0;
                w_col_nx   = '0;
                w_base_nx  = '0;
                w_ptr_nx   = '0;
                w_state_nx = CLEAR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      default: w_state_nx = CLEAR_ALL;
    endcase

    // New-line advance: no scrolling, the bottom row wraps to the top.
    if (w_newline) begin
      w_col_nx = '0;
      if (r_row == ROW_LAST) begin
        w_row_nx  = '0;
        w_base_nx = '0;
      end else begin
        w_row_nx  = r_row + 5'd1;
        w_base_nx = r_base + LINE_STEP;
      end
      w_ptr_nx   = w_base_nx;
      w_state_nx = CLEAR_LINE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= CLEAR_ALL;
      r_ptr     <= '0;
      r_base    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_ptr     <= w_ptr_nx;
      r_base    <= w_base_nx;
      r_row     <= w_row_nx;
      r_col     <= w_col_nx;
      r_done    <= w_done_nx;
      r_wr_en   <= w_wr_en_nx;
      r_wr_addr <= w_wr_addr_nx;
      r_wr_data <= w_wr_data_nx;
    end
  end

  assign in_ready    = (r_state == IDLE) && !RESET;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign cursor_addr = w_cursor;

endmodule
